// File: rtl/l2_cache_plru_tree_if.sv
// l2_cache_plru_tree_if
//   Bundles the L2 controller <-> PLRU engine signals.
//   master : L2 controller (drives clear/touch/victim request, receives victim result)
//   slave  : PLRU engine
//
//   Handshake semantics: there is no ready. touch_valid_i and victim_req_i
//   are accepted at every rising edge where they are 1. Every accepted victim
//   request produces exactly one victim_valid_o pulse in the following cycle.
//   victim_way_o/victim_none_o are meaningful only while victim_valid_o=1.
//   Indices and masks are don't-care while their valid/req is 0.
//
//   Signals:
//     clear_i        flush all tree state
//     touch_valid_i  record an access to (touch_index_i, touch_way_i)
//     victim_req_i   request a victim for victim_index_i using valid/lock masks
//     victim_valid_o 1-cycle result pulse
//     victim_way_o   chosen way (0 when victim_none_o)
//     victim_none_o  every way locked
interface l2_cache_plru_tree_if #(
  parameter int WAYS = 8,
  parameter int SETS = 128
);
  localparam int WAY_W = $clog2(WAYS);
  localparam int IDX_W = $clog2(SETS);

  logic             clear_i;
  logic             touch_valid_i;
  logic [IDX_W-1:0] touch_index_i;
  logic [WAY_W-1:0] touch_way_i;
  logic             victim_req_i;
  logic [IDX_W-1:0] victim_index_i;
  logic [WAYS-1:0]  valid_mask_i;
  logic [WAYS-1:0]  lock_mask_i;
  logic             victim_valid_o;
  logic [WAY_W-1:0] victim_way_o;
  logic             victim_none_o;

  modport master (
    output clear_i, touch_valid_i, touch_index_i, touch_way_i,
    output victim_req_i, victim_index_i, valid_mask_i, lock_mask_i,
    input  victim_valid_o, victim_way_o, victim_none_o
  );

  modport slave (
    input  clear_i, touch_valid_i, touch_index_i, touch_way_i,
    input  victim_req_i, victim_index_i, valid_mask_i, lock_mask_i,
    output victim_valid_o, victim_way_o, victim_none_o
  );
endinterface

// File: rtl/l2_cache_plru_tree.sv
// l2_cache_plru_tree
//   Tree pseudo-LRU replacement engine for the L2 cache. Keeps WAYS-1 tree
//   bits per set (heap numbered 1..WAYS-1, children 2n / 2n+1), updates the
//   path on every touch and returns a registered victim one cycle after a
//   request. Invalid unlocked ways win first; otherwise the tree walk steers
//   away from recent accesses while avoiding fully locked subtrees.
//
//   Ports:
//     clk_i  clock, all state on rising edge
//     rst_i  asynchronous active-high reset
//     bus    l2_cache_plru_tree_if.slave (touch / victim request / result)
module l2_cache_plru_tree #(
  parameter int WAYS = 8,
  parameter int SETS = 128
) (
  input logic                 clk_i,
  input logic                 rst_i,
  l2_cache_plru_tree_if.slave bus
);
  localparam int WAY_W = $clog2(WAYS);
  localparam int IDX_W = $clog2(SETS);

  typedef logic [WAYS-1:1] tree_t;

  tree_t tree_q [SETS];

  // Write the way's bits into the nodes on its root-to-leaf path.
  function automatic tree_t touch_path(tree_t t, logic [WAY_W-1:0] way);
    tree_t            r;
    int               node;
    logic [WAY_W-1:0] sh;
    r    = t;
    node = 1;
    for (int l = 0; l < WAY_W; l++) begin
      sh = way >> (WAY_W - 1 - l);
      r[WAY_W'(node)] = sh[0];
      node = 2 * node + int'(sh[0]);
    end
    return r;
  endfunction

  // Walk from the root opposite to each stored bit, unless the preferred
  // child subtree is fully locked. Caller guarantees at least one unlocked way,
  // so the non-preferred child is then always usable.
  function automatic logic [WAY_W-1:0] walk(tree_t t, logic [WAYS-1:0] lk);
    logic [WAY_W-1:0] w;
    int               node;
    int               left_pfx;
    logic             l_free;
    logic             r_free;
    logic             down;
    w    = '0;
    node = 1;
    for (int l = 0; l < WAY_W; l++) begin
      // Ways under the left child share this (l+1)-bit prefix.
      left_pfx = 2 * node - (2 << l);
      l_free   = 1'b0;
      r_free   = 1'b0;
      for (int i = 0; i < WAYS; i++) begin
        if (!lk[i] && ((i >> (WAY_W - 1 - l)) == left_pfx))     l_free = 1'b1;
        if (!lk[i] && ((i >> (WAY_W - 1 - l)) == left_pfx + 1)) r_free = 1'b1;
      end
      down = ~t[WAY_W'(node)];
      if (down && !r_free)      down = 1'b0;
      else if (!down && !l_free) down = 1'b1;
      w    = (w << 1) | WAY_W'(down);
      node = 2 * node + int'(down);
    end
    return w;
  endfunction

  // {found, way}: lowest-numbered way that is invalid and not locked.
  function automatic logic [WAY_W:0] pick_invalid(logic [WAYS-1:0] vm, logic [WAYS-1:0] lk);
    logic [WAY_W:0] r;
    r = '0;
    for (int i = WAYS - 1; i >= 0; i--) begin
      if (!vm[i] && !lk[i]) r = {1'b1, WAY_W'(i)};
    end
    return r;
  endfunction

  tree_t            cur_tree;
  logic [WAY_W:0]   inv_pick;
  logic [WAY_W-1:0] sel_way;
  logic             sel_none;
  logic             victim_valid_q;
  logic [WAY_W-1:0] victim_way_q;
  logic             victim_none_q;

  // Victim set view: cleared tree during a flush, otherwise the stored tree
  // with a same-set touch from this cycle forwarded in.
  always_comb begin
    cur_tree = tree_q[bus.victim_index_i];
    if (bus.clear_i) begin
      cur_tree = '0;
    end else if (bus.touch_valid_i && (bus.touch_index_i == bus.victim_index_i)) begin
      cur_tree = touch_path(cur_tree, bus.touch_way_i);
    end
    inv_pick = pick_invalid(bus.valid_mask_i, bus.lock_mask_i);
    sel_none = &bus.lock_mask_i;
    sel_way  = '0;
    if (inv_pick[WAY_W]) begin
      sel_way = inv_pick[WAY_W-1:0];
    end else if (!sel_none) begin
      sel_way = walk(cur_tree, bus.lock_mask_i);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int s = 0; s < SETS; s++) tree_q[s] <= '0;
    end else if (bus.clear_i) begin
      for (int s = 0; s < SETS; s++) tree_q[s] <= '0;
    end else if (bus.touch_valid_i) begin
      tree_q[bus.touch_index_i] <= touch_path(tree_q[bus.touch_index_i], bus.touch_way_i);
    end
  end

  // Result registers are zeroed when no request is taken so that indices
  // left floating between requests never reach the outputs.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      victim_valid_q <= 1'b0;
      victim_way_q   <= '0;
      victim_none_q  <= 1'b0;
    end else begin
      victim_valid_q <= bus.victim_req_i;
      victim_way_q   <= bus.victim_req_i ? sel_way : '0;
      victim_none_q  <= bus.victim_req_i & sel_none;
    end
  end

  assign bus.victim_valid_o = victim_valid_q;
  assign bus.victim_way_o   = victim_way_q;
  assign bus.victim_none_o  = victim_none_q;
endmodule
